// File: rtl/idma_mp_dist_midend.sv
// Steers single-region iDMA requests to one of NumBwPorts backends by region index
// and merges backend responses back into issue order through a FIFO of port indices.
package idma_mp_dist_pkg;
  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] length;
  } idma_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } idma_rsp_t;
endpackage

module idma_mp_dist_midend #(
  parameter int unsigned          NumBwPorts     = 2,
  parameter int unsigned          RegionWidth    = 64,
  parameter int unsigned          AddrWidth      = 32,
  parameter logic [AddrWidth-1:0] RegionStart    = 32'h0000_0000,
  parameter logic [AddrWidth-1:0] RegionEnd      = 32'h1000_0000,
  parameter int unsigned          MaxOutstanding = 8,
  parameter type                  idma_req_t     = idma_mp_dist_pkg::idma_req_t,
  parameter type                  idma_rsp_t     = idma_mp_dist_pkg::idma_rsp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  idma_req_t             idma_req_i,
  input  logic                  idma_req_valid_i,
  output logic                  idma_req_ready_o,
  output idma_rsp_t             idma_rsp_o,
  output logic                  idma_rsp_valid_o,
  input  logic                  idma_rsp_ready_i,
  output idma_req_t             idma_req_o       [NumBwPorts],
  output logic [NumBwPorts-1:0] idma_req_valid_o,
  input  logic [NumBwPorts-1:0] idma_req_ready_i,
  input  idma_rsp_t             idma_rsp_i       [NumBwPorts],
  input  logic [NumBwPorts-1:0] idma_rsp_valid_i,
  output logic [NumBwPorts-1:0] idma_rsp_ready_o,
  output logic                  busy_o
);

  localparam int unsigned RB = $clog2(RegionWidth);
  localparam int unsigned PB = $clog2(NumBwPorts);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  // Handshake rule on every channel: a transfer happens in the cycle where valid and
  // ready are both high; valid never waits on ready, ready never waits on valid.

  logic [AddrWidth-1:0] src_off;
  logic                 src_in_range;
  logic [RB+PB-1:0]     sel_addr;
  logic [PB-1:0]        sel;
  logic [PB-1:0]        head;
  logic                 full, empty, push, pop;

  logic [PB-1:0] mem_q [MaxOutstanding];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  // One unsigned compare covers both bounds of the distributed window.
  assign src_off      = AddrWidth'(idma_req_i.src_addr) - RegionStart;
  assign src_in_range = src_off < (RegionEnd - RegionStart);
  assign sel_addr     = src_in_range ? idma_req_i.src_addr[RB+PB-1:0]
                                     : idma_req_i.dst_addr[RB+PB-1:0];
  assign sel          = sel_addr[RB +: PB];

  assign full  = (count_q == CW'(MaxOutstanding));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  assign idma_req_ready_o = idma_req_ready_i[sel] & ~full;
  assign idma_rsp_o       = idma_rsp_i[head];
  assign idma_rsp_valid_o = ~empty & idma_rsp_valid_i[head];
  assign busy_o           = ~empty;

  assign push = idma_req_valid_i & idma_req_ready_o;
  assign pop  = idma_rsp_valid_o & idma_rsp_ready_i;

  always_comb begin
    for (int unsigned p = 0; p < NumBwPorts; p++) begin
      idma_req_o[p]       = idma_req_i;
      idma_req_valid_o[p] = idma_req_valid_i & ~full & (sel == PB'(p));
      idma_rsp_ready_o[p] = ~empty & idma_rsp_ready_i & (head == PB'(p));
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(MaxOutstanding - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  logic [AddrWidth-1:0] region_end_off;
  assign region_end_off = AddrWidth'(sel_addr[RB-1:0]) + AddrWidth'(idma_req_i.length);

  a_no_region_cross: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (idma_req_valid_i && idma_req_i.length != '0) |-> region_end_off <= AddrWidth'(RegionWidth));

  a_no_rsp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    empty |-> (idma_rsp_valid_i == '0));

endmodule

// File: tb/tb_idma_mp_dist_midend.sv
// Directed bench for idma_mp_dist_midend: combinational steering table plus
// multi-cycle ordering, full-FIFO and reset sequences.
module tb_idma_mp_dist_midend;
  import idma_mp_dist_pkg::*;

  localparam int NP = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  idma_req_t     req_i;
  logic          req_valid_i;
  logic          req_ready_o;
  idma_rsp_t     rsp_o;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  idma_req_t     be_req_o       [NP];
  logic [NP-1:0] be_req_valid_o;
  logic [NP-1:0] be_req_ready_i;
  idma_rsp_t     be_rsp_i       [NP];
  logic [NP-1:0] be_rsp_valid_i;
  logic [NP-1:0] be_rsp_ready_o;
  logic          busy_o;

  idma_mp_dist_midend #(
    .NumBwPorts    (NP),
    .RegionWidth   (64),
    .AddrWidth     (32),
    .RegionStart   (32'h0000_0000),
    .RegionEnd     (32'h0000_1000),
    .MaxOutstanding(2)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .idma_req_i      (req_i),
    .idma_req_valid_i(req_valid_i),
    .idma_req_ready_o(req_ready_o),
    .idma_rsp_o      (rsp_o),
    .idma_rsp_valid_o(rsp_valid_o),
    .idma_rsp_ready_i(rsp_ready_i),
    .idma_req_o      (be_req_o),
    .idma_req_valid_o(be_req_valid_o),
    .idma_req_ready_i(be_req_ready_i),
    .idma_rsp_i      (be_rsp_i),
    .idma_rsp_valid_i(be_rsp_valid_i),
    .idma_rsp_ready_o(be_rsp_ready_o),
    .busy_o          (busy_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_req(input logic v, input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] len);
    req_i.src_addr = src;
    req_i.dst_addr = dst;
    req_i.length   = len;
    req_valid_i    = v;
  endtask

  task automatic set_rsp(input int p, input logic v, input logic [31:0] d);
    be_rsp_i[p].data  = d;
    be_rsp_i[p].error = 1'b0;
    be_rsp_valid_i[p] = v;
  endtask

  function automatic logic [63:0] rsp_word(input logic [31:0] d);
    idma_rsp_t r;
    r.data  = d;
    r.error = 1'b0;
    return 64'(r);
  endfunction

  typedef struct {
    logic        v;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic [3:0]  rdy;
    logic [3:0]  exp_v;
    logic        exp_r;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // scoreboard table: region index is addr[7:6]; src used only inside [0, 0x1000)
    vecs[0] = '{1'b1, 32'h0000_0040, 32'h0000_8000, 32'd64, 4'b1111, 4'b0010, 1'b1};
    vecs[1] = '{1'b1, 32'h0000_9000, 32'h0000_00C0, 32'd32, 4'b1111, 4'b1000, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_0FC0, 32'h0000_0000, 32'd64, 4'b0111, 4'b1000, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_1000, 32'h0000_0100, 32'd16, 4'b0001, 4'b0001, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0080, 32'h0000_0000, 32'd0,  4'b1011, 4'b0100, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0040, 32'd64, 4'b1110, 4'b0001, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0140, 32'h0000_0000, 32'd8,  4'b0010, 4'b0000, 1'b1};

    rst_ni         = 1'b0;
    rsp_ready_i    = 1'b1;
    be_req_ready_i = 4'b1111;
    be_rsp_valid_i = '0;
    for (int p = 0; p < NP; p++) set_rsp(p, 1'b0, 32'h0);
    drive_req(1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // reset state
    #2;
    chk("reset_req_valid", 64'(be_req_valid_o), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'h0);
    chk("reset_rsp_ready", 64'(be_rsp_ready_o), 64'h0);
    chk("reset_busy", 64'(busy_o), 64'h0);
    chk("reset_req_ready_follow", 64'(req_ready_o), 64'h1);
    be_req_ready_i = 4'b1110;
    #1;
    chk("reset_req_ready_port0_low", 64'(req_ready_o), 64'h0);

    // combinational steering table; valid drops before the next edge
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      be_req_ready_i = vecs[i].rdy;
      drive_req(vecs[i].v, vecs[i].src, vecs[i].dst, vecs[i].len);
      #2;
      chk($sformatf("vec%0d_valid", i), 64'(be_req_valid_o), 64'(vecs[i].exp_v));
      chk($sformatf("vec%0d_ready", i), 64'(req_ready_o), 64'(vecs[i].exp_r));
      chk($sformatf("vec%0d_busy", i), 64'(busy_o), 64'h0);
      req_valid_i = 1'b0;
    end

    // single transaction on port 1
    @(negedge clk_i);
    be_req_ready_i = 4'b1111;
    drive_req(1'b1, 32'h0000_0040, 32'h0000_8000, 32'd64);
    #2;
    chk("a_req_valid", 64'(be_req_valid_o), 64'h2);
    chk("a_req_ready", 64'(req_ready_o), 64'h1);
    chk("a_req_fwd_src", 64'(be_req_o[1].src_addr), 64'h40);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #2;
    chk("a_busy", 64'(busy_o), 64'h1);
    chk("a_rsp_ready_head", 64'(be_rsp_ready_o), 64'h2);
    set_rsp(1, 1'b1, 32'h0000_00A1);
    #1;
    chk("a_rsp_valid", 64'(rsp_valid_o), 64'h1);
    chk("a_rsp_data", 64'(rsp_o), rsp_word(32'h0000_00A1));
    @(negedge clk_i);
    set_rsp(1, 1'b0, 32'h0);
    #2;
    chk("a_busy_drop", 64'(busy_o), 64'h0);

    // in-order merge: port 2 issued first, port 0 answers first
    @(negedge clk_i);
    drive_req(1'b1, 32'h0000_0080, 32'h0, 32'd64);
    @(negedge clk_i);
    drive_req(1'b1, 32'h0000_0000, 32'h0, 32'd64);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    set_rsp(0, 1'b1, 32'h0000_00B0);
    #2;
    chk("b_port0_stalled", 64'(be_rsp_ready_o), 64'h4);
    chk("b_no_merged_valid", 64'(rsp_valid_o), 64'h0);
    @(negedge clk_i);
    #2;
    chk("b_port0_still_stalled", 64'(be_rsp_ready_o), 64'h4);
    set_rsp(2, 1'b1, 32'h0000_00B2);
    #1;
    chk("b_head_valid", 64'(rsp_valid_o), 64'h1);
    chk("b_head_data", 64'(rsp_o), rsp_word(32'h0000_00B2));
    @(negedge clk_i);
    set_rsp(2, 1'b0, 32'h0);
    #2;
    chk("b_second_ready", 64'(be_rsp_ready_o), 64'h1);
    chk("b_second_valid", 64'(rsp_valid_o), 64'h1);
    chk("b_second_data", 64'(rsp_o), rsp_word(32'h0000_00B0));
    chk("b_busy_mid", 64'(busy_o), 64'h1);
    @(negedge clk_i);
    set_rsp(0, 1'b0, 32'h0);
    #2;
    chk("b_busy_drop", 64'(busy_o), 64'h0);

    // full FIFO blocks a third request until a pop
    @(negedge clk_i);
    drive_req(1'b1, 32'h0000_0040, 32'h0, 32'd64);
    @(negedge clk_i);
    drive_req(1'b1, 32'h0000_00C0, 32'h0, 32'd64);
    @(negedge clk_i);
    drive_req(1'b1, 32'h0000_0000, 32'h0, 32'd64);
    #2;
    chk("c_full_ready", 64'(req_ready_o), 64'h0);
    chk("c_full_valids", 64'(be_req_valid_o), 64'h0);
    set_rsp(1, 1'b1, 32'h0000_00C1);
    #1;
    chk("c_pop_valid", 64'(rsp_valid_o), 64'h1);
    chk("c_ready_same_cycle_pop", 64'(req_ready_o), 64'h0);
    @(negedge clk_i);
    set_rsp(1, 1'b0, 32'h0);
    #2;
    chk("c_ready_after_pop", 64'(req_ready_o), 64'h1);
    chk("c_valid_after_pop", 64'(be_req_valid_o), 64'h1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    set_rsp(3, 1'b1, 32'h0000_00C3);
    #2;
    chk("c_head_port3", 64'(be_rsp_ready_o), 64'h8);
    @(negedge clk_i);
    set_rsp(3, 1'b0, 32'h0);
    set_rsp(0, 1'b1, 32'h0000_00C0);
    #2;
    chk("c_head_port0", 64'(be_rsp_ready_o), 64'h1);
    chk("c_head_port0_data", 64'(rsp_o), rsp_word(32'h0000_00C0));
    @(negedge clk_i);
    set_rsp(0, 1'b0, 32'h0);
    #2;
    chk("c_busy_drop", 64'(busy_o), 64'h0);

    // backpressure hold, then reset mid-stream
    @(negedge clk_i);
    drive_req(1'b1, 32'h0000_0080, 32'h0, 32'd64);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    set_rsp(2, 1'b1, 32'h0000_00D2);
    #2;
    chk("d_hold_valid", 64'(rsp_valid_o), 64'h1);
    chk("d_hold_ready", 64'(be_rsp_ready_o), 64'h0);
    repeat (2) @(negedge clk_i);
    #2;
    chk("d_hold_data", 64'(rsp_o), rsp_word(32'h0000_00D2));
    chk("d_hold_busy", 64'(busy_o), 64'h1);
    rst_ni = 1'b0;
    #1;
    chk("d_rst_busy", 64'(busy_o), 64'h0);
    chk("d_rst_rsp_ready", 64'(be_rsp_ready_o), 64'h0);
    chk("d_rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    rsp_ready_i = 1'b1;
    set_rsp(0, 1'b1, 32'h0000_00D0);
    #1;
    chk("d_rst_rsp_ready_rdy", 64'(be_rsp_ready_o), 64'h0);
    @(negedge clk_i);
    #2;
    chk("d_rst_rsp_ready_cycle", 64'(be_rsp_ready_o), 64'h0);
    set_rsp(0, 1'b0, 32'h0);
    set_rsp(2, 1'b0, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #2;
    chk("d_post_busy", 64'(busy_o), 64'h0);
    chk("d_post_rsp_ready", 64'(be_rsp_ready_o), 64'h0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/idma_mp_dist_midend.md
# idma_mp_dist_midend

Multi-port distribution midend sitting directly downstream of the region-split midend. It takes a single stream of iDMA requests, each already confined to one address region, and steers each request to one of `NumBwPorts` backend ports selected by the region index. Responses from the backends are merged back into a single in-order stream using an issue-order FIFO of port indices.

## Interface
- `NumBwPorts`, 2: number of backend ports; power of two, ≥2.
- `RegionWidth`, 64: bytes per region; power of two.
- `RegionStart`, 32'h0000_0000: base of the distributed address range.
- `RegionEnd`, 32'h1000_0000: end (exclusive) of the distributed address range.
- `AddrWidth`, 32: address width.
- `MaxOutstanding`, 8: depth of the issue-order FIFO, ≥1.
- `idma_req_t`, logic: request struct with `src_addr`, `dst_addr`, `length`.
- `idma_rsp_t`, logic: response struct.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `idma_req_i`  in  idma_req_t  request from the split stage.
- `idma_req_valid_i`  in  1  request valid.
- `idma_req_ready_o`  out  1  request ready.
- `idma_rsp_o`  out  idma_rsp_t  merged response.
- `idma_rsp_valid_o`  out  1  merged response valid.
- `idma_rsp_ready_i`  in  1  merged response ready.
- `idma_req_o`  out  [NumBwPorts] idma_req_t  per-port request; all ports carry `idma_req_i`.
- `idma_req_valid_o`  out  [NumBwPorts]  per-port valid.
- `idma_req_ready_i`  in  [NumBwPorts]  per-port ready.
- `idma_rsp_i`  in  [NumBwPorts] idma_rsp_t  per-port response.
- `idma_rsp_valid_i`  in  [NumBwPorts]  per-port response valid.
- `idma_rsp_ready_o`  out  [NumBwPorts]  per-port response ready.
- `busy_o`  out  1  high while any request is outstanding (FIFO non-empty).

## Operation
- Address select: use `src_addr` if RegionStart ≤ src_addr < RegionEnd, else `dst_addr`.
- Port index `sel = addr[RB +: PB]`, where RB = $clog2(RegionWidth) and PB = $clog2(NumBwPorts). Modulo wrap is implicit via bit slicing.
- Request path:
  - `idma_req_valid_o[sel] = idma_req_valid_i & !full`; all other valids are 0.
  - `idma_req_ready_o = idma_req_ready_i[sel] & !full`.
  - On handshake, push `sel` into the order FIFO.
- Order FIFO: `MaxOutstanding` entries of PB bits, plus an occupancy counter of width $clog2(MaxOutstanding+1). No fall-through.
- Response path:
  - `head` = FIFO head.
  - `idma_rsp_o = idma_rsp_i[head]`.
  - `idma_rsp_valid_o = !empty & idma_rsp_valid_i[head]`.
  - `idma_rsp_ready_o[head] = !empty & idma_rsp_ready_i`; all other readys are 0.
  - Pop on merged-response handshake.
- Responses on non-head ports are stalled (ready 0) until their index reaches the head. This enforces in-order delivery.
- Simultaneous push and pop: both take effect and the occupancy count is unchanged.
  - A push while full is blocked regardless of a same-cycle pop; ready depends only on registered `full`.
- `busy_o = !empty`.
- Simulation-only assertions:
  - A request with `length` ≠ 0 must not cross a region boundary: `addr[RB-1:0] + length ≤ RegionWidth`.
  - Flag any valid response on a port while the FIFO is empty.

## Timing
- Request forwarding is combinational, 0 cycles; valid/ready do not depend on each other in the same direction.
- Response merge is combinational, 0 cycles.
- A pushed index becomes visible at the head at the earliest 1 cycle after the request handshake. A same-cycle backend response is not accepted.
- Reset state: FIFO empty, count 0, pointers 0. With inputs idle this gives:
  - all `idma_req_valid_o` = 0, `idma_rsp_valid_o` = 0;
  - all `idma_rsp_ready_o` = 0, `busy_o` = 0;
  - `idma_req_ready_o` follows `idma_req_ready_i[sel]`.
- Reset mid-operation discards all outstanding order entries. Backend responses arriving afterwards are not accepted (ready 0).
- Full: `count == MaxOutstanding` blocks requests until the next pop. Ready returns the cycle after the pop.

## Test plan
Configuration: NumBwPorts=4, RegionWidth=64, Region 0x0–0x1000, MaxOutstanding=2.
- src=0x0040, dst=0x8000, len=64, all ports ready → `idma_req_valid_o`=4'b0010, handshake in 1 cycle, `busy_o`=1 next cycle.
- src=0x9000, dst=0x00C0, len=32 → `dst` is used, `idma_req_valid_o`=4'b1000.
- Issue to port 2 then port 0; port 0 responds first → `idma_rsp_ready_o[0]`=0 until port 2's response is handshaked, then port 0's response is delivered the following cycle; `busy_o` drops after the second pop.
- Two requests outstanding, third valid → `idma_req_ready_o`=0 and all valids 0; one response popped → third request accepted the next cycle.
- `idma_rsp_ready_i`=0 with the head response valid → the head entry is held and `idma_rsp_o` is stable; then assert `rst_ni`=0 mid-stream → `busy_o`=0 and all `idma_rsp_ready_o`=0 while the backends still assert valid.
